// File: rtl/reversalmb_param_fsm_pkg.sv
// Shared MBINIT definitions: sideband message codes and the lane-reversal FSM states.
package reversalmb_param_fsm_pkg;

    localparam logic [3:0] MSG_NONE        = 4'b0000;
    localparam logic [3:0] MSG_INIT_REQ    = 4'b0001;
    localparam logic [3:0] MSG_INIT_RESP   = 4'b0010;
    localparam logic [3:0] MSG_CLEAR_REQ   = 4'b0011;
    localparam logic [3:0] MSG_CLEAR_RESP  = 4'b0100;
    localparam logic [3:0] MSG_RESULT_REQ  = 4'b0101;
    localparam logic [3:0] MSG_RESULT_RESP = 4'b0110;
    localparam logic [3:0] MSG_DONE_REQ    = 4'b0111;
    localparam logic [3:0] MSG_DONE_RESP   = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_REQ,
        ST_CLEAR_REQ,
        ST_LANEID_PAT,
        ST_RESULT_REQ,
        ST_DONE_REQ,
        ST_WAIT_RESP,
        ST_CHECK,
        ST_APPLY,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Request code sent while sitting in a *_REQ state; MSG_NONE elsewhere.
    function automatic logic [3:0] req_code(input state_t s);
        case (s)
            ST_INIT_REQ:   req_code = MSG_INIT_REQ;
            ST_CLEAR_REQ:  req_code = MSG_CLEAR_REQ;
            ST_RESULT_REQ: req_code = MSG_RESULT_REQ;
            ST_DONE_REQ:   req_code = MSG_DONE_REQ;
            default:       req_code = MSG_NONE;
        endcase
    endfunction

    // Every response code is the code of its request plus one.
    function automatic logic [3:0] resp_code(input logic [3:0] req);
        resp_code = req + 4'd1;
    endfunction

endpackage

// File: rtl/reversalmb_param_fsm_lane_popcount.sv
// Purely combinational count of passing lanes.
module lane_popcount #(
    parameter int NUM_LANES = 16
) (
    input  logic [NUM_LANES-1:0]         lanes_i,
    output logic [$clog2(NUM_LANES+1)-1:0] count_o
);

    localparam int CW = $clog2(NUM_LANES + 1);

    // Sum the per-lane pass bits at full width.
    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            count_o = count_o + CW'(lanes_i[i]);
        end
    end

endmodule

// File: rtl/reversalmb_param_fsm.sv
// MBINIT lane-reversal sequencer: init/clear/lane-id/result handshakes over the
// sideband, pass-count check, bounded reversal retries, done or error.
module reversalmb_param_fsm
    import reversalmb_param_fsm_pkg::*;
#(
    parameter int NUM_LANES      = 16,
    parameter int PASS_THRESHOLD = 8,
    parameter int MAX_ATTEMPTS   = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           CLK,
    input  logic                           rst,
    input  logic                           i_enable,
    input  logic                           i_busy_sideband,
    input  logic                           i_falling_edge_busy,
    input  logic                           i_msg_valid,
    input  logic [3:0]                     i_rx_sb_message,
    input  logic                           i_laneid_pattern_done,
    input  logic                           i_reversal_done,
    input  logic [NUM_LANES-1:0]           i_result_logged,
    output logic [3:0]                     o_tx_sb_message,
    output logic                           o_valid_out,
    output logic [1:0]                     o_laneid_pattern_en,
    output logic                           o_apply_reversal_en,
    output logic                           o_module_end,
    output logic                           o_train_error_req,
    output logic                           o_reversal_applied,
    output logic [$clog2(NUM_LANES+1)-1:0] o_pass_count
);

    localparam int PCW = $clog2(NUM_LANES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES);
    localparam int AW  = (MAX_ATTEMPTS < 1) ? 1 : $clog2(MAX_ATTEMPTS + 1);

    state_t          state_q, state_d;
    logic [3:0]      exp_q, exp_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   attempts_q, attempts_d;
    logic            pend_q, pend_d;
    logic            applied_q, applied_d;
    logic [PCW-1:0]  pass_q, pass_d;
    logic [PCW-1:0]  popcount;
    logic            resp_match;

    logic [3:0]      tx_q, tx_d;
    logic            valid_q, valid_d;
    logic [1:0]      laneid_q, laneid_d;
    logic            apply_q, apply_d;
    logic            end_q, end_d;
    logic            err_q, err_d;

    lane_popcount #(
        .NUM_LANES (NUM_LANES)
    ) u_popcount (
        .lanes_i (i_result_logged),
        .count_o (popcount)
    );

    assign resp_match = i_msg_valid && (i_rx_sb_message == exp_q);

    // Next-state decode plus attempts, expected-code, timeout and pass-count updates.
    // pend_q remembers an event that already fired while entry to the next *_REQ
    // state is held back by a busy sideband, so a one-cycle pulse is not lost.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        cnt_d      = '0;
        pend_d     = 1'b0;
        attempts_d = attempts_q;
        applied_d  = applied_q;
        pass_d     = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && !i_busy_sideband) state_d = ST_INIT_REQ;
            end
            ST_INIT_REQ, ST_CLEAR_REQ, ST_RESULT_REQ, ST_DONE_REQ: begin
                if (i_falling_edge_busy && !i_busy_sideband) begin
                    state_d = ST_WAIT_RESP;
                    exp_d   = resp_code(req_code(state_q));
                end
            end
            ST_LANEID_PAT: begin
                if (i_laneid_pattern_done || pend_q) begin
                    if (i_busy_sideband) pend_d  = 1'b1;
                    else                 state_d = ST_RESULT_REQ;
                end
            end
            ST_WAIT_RESP: begin
                cnt_d = cnt_q + TW'(1);
                if (!pend_q && (cnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
                    state_d = ST_ERROR;
                end else if (resp_match || pend_q) begin
                    case (exp_q)
                        MSG_INIT_RESP: begin
                            if (i_busy_sideband) pend_d  = 1'b1;
                            else                 state_d = ST_CLEAR_REQ;
                        end
                        MSG_CLEAR_RESP:  state_d = ST_LANEID_PAT;
                        MSG_RESULT_RESP: begin
                            state_d = ST_CHECK;
                            pass_d  = popcount;
                        end
                        MSG_DONE_RESP:   state_d = ST_DONE;
                        default:         state_d = ST_ERROR;
                    endcase
                end
            end
            ST_CHECK: begin
                if (pass_q >= PCW'(PASS_THRESHOLD)) begin
                    if (!i_busy_sideband) state_d = ST_DONE_REQ;
                end else if (attempts_q < AW'(MAX_ATTEMPTS)) begin
                    state_d    = ST_APPLY;
                    attempts_d = attempts_q + AW'(1);
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_APPLY: begin
                if (i_reversal_done || pend_q) begin
                    if (i_busy_sideband) begin
                        pend_d = 1'b1;
                    end else begin
                        state_d   = ST_CLEAR_REQ;
                        applied_d = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything above, including a same-cycle response.
        if ((state_q != ST_IDLE) && !i_enable) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            pend_d     = 1'b0;
            attempts_d = '0;
            applied_d  = 1'b0;
            pass_d     = '0;
        end
    end

    // Output decode from the next state so outputs line up with the state's first cycle.
    always_comb begin
        tx_d     = req_code(state_d);
        valid_d  = (tx_d != MSG_NONE);
        laneid_d = (state_d == ST_LANEID_PAT) ? 2'b11 : 2'b00;
        apply_d  = (state_d == ST_APPLY);
        end_d    = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERROR);
    end

    // State, bookkeeping and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            exp_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            attempts_q <= '0;
            applied_q  <= 1'b0;
            pass_q     <= '0;
            tx_q       <= '0;
            valid_q    <= 1'b0;
            laneid_q   <= '0;
            apply_q    <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            attempts_q <= attempts_d;
            applied_q  <= applied_d;
            pass_q     <= pass_d;
            tx_q       <= tx_d;
            valid_q    <= valid_d;
            laneid_q   <= laneid_d;
            apply_q    <= apply_d;
            end_q      <= end_d;
            err_q      <= err_d;
        end
    end

    assign o_tx_sb_message     = tx_q;
    assign o_valid_out         = valid_q;
    assign o_laneid_pattern_en = laneid_q;
    assign o_apply_reversal_en = apply_q;
    assign o_module_end        = end_q;
    assign o_train_error_req   = err_q;
    assign o_reversal_applied  = applied_q;
    assign o_pass_count        = pass_q;

endmodule

// File: tb/tb_reversalmb_param_fsm.sv
// Bench for the MBINIT lane-reversal sequencer: a sideband responder plus a
// training-outcome model driven by directed and random per-lane results.
module tb_reversalmb_param_fsm;

    localparam int NL      = 16;
    localparam int THR     = 8;
    localparam int MAX_ATT = 1;
    localparam int TO      = 16;

    localparam logic [3:0] C_INIT_REQ    = 4'b0001;
    localparam logic [3:0] C_INIT_RESP   = 4'b0010;
    localparam logic [3:0] C_CLEAR_REQ   = 4'b0011;
    localparam logic [3:0] C_CLEAR_RESP  = 4'b0100;
    localparam logic [3:0] C_RESULT_REQ  = 4'b0101;
    localparam logic [3:0] C_RESULT_RESP = 4'b0110;
    localparam logic [3:0] C_DONE_REQ    = 4'b0111;
    localparam logic [3:0] C_DONE_RESP   = 4'b1000;

    logic          CLK = 1'b0;
    logic          rst;
    logic          i_enable, i_busy_sideband, i_falling_edge_busy, i_msg_valid;
    logic [3:0]    i_rx_sb_message;
    logic          i_laneid_pattern_done, i_reversal_done;
    logic [NL-1:0] i_result_logged;
    logic [3:0]    o_tx_sb_message;
    logic          o_valid_out;
    logic [1:0]    o_laneid_pattern_en;
    logic          o_apply_reversal_en, o_module_end, o_train_error_req, o_reversal_applied;
    logic [4:0]    o_pass_count;
    logic [15:0]   all_o;

    int n_checks = 0;
    int n_pass   = 0;
    int apply_rises = 0;
    logic apply_prev = 1'b0;

    reversalmb_param_fsm #(
        .NUM_LANES      (NL),
        .PASS_THRESHOLD (THR),
        .MAX_ATTEMPTS   (MAX_ATT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK                   (CLK),
        .rst                   (rst),
        .i_enable              (i_enable),
        .i_busy_sideband       (i_busy_sideband),
        .i_falling_edge_busy   (i_falling_edge_busy),
        .i_msg_valid           (i_msg_valid),
        .i_rx_sb_message       (i_rx_sb_message),
        .i_laneid_pattern_done (i_laneid_pattern_done),
        .i_reversal_done       (i_reversal_done),
        .i_result_logged       (i_result_logged),
        .o_tx_sb_message       (o_tx_sb_message),
        .o_valid_out           (o_valid_out),
        .o_laneid_pattern_en   (o_laneid_pattern_en),
        .o_apply_reversal_en   (o_apply_reversal_en),
        .o_module_end          (o_module_end),
        .o_train_error_req     (o_train_error_req),
        .o_reversal_applied    (o_reversal_applied),
        .o_pass_count          (o_pass_count)
    );

    assign all_o = {o_tx_sb_message, o_valid_out, o_laneid_pattern_en, o_apply_reversal_en,
                    o_module_end, o_train_error_req, o_reversal_applied, o_pass_count};

    always #5 CLK = ~CLK;

    // Count APPLY entries seen on the output.
    always @(negedge CLK) begin
        if (o_apply_reversal_en === 1'b1 && apply_prev !== 1'b1) apply_rises++;
        apply_prev = o_apply_reversal_en;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got running, required finished)");
        $fatal(1, "watchdog");
    end

    // Bounded wait for an output level; an expired bound is a failed comparison.
    task automatic wait_sig(input int which, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge CLK);
            case (which)
                0:       hit = o_valid_out;
                1:       hit = (o_laneid_pattern_en != 2'b00);
                2:       hit = o_apply_reversal_en;
                3:       hit = o_module_end;
                default: hit = o_train_error_req;
            endcase
        end
        n_checks++;
        if (!hit) $display("FAIL wait_%s: got not reached in 64 cycles, required reached", name);
        else n_pass++;
    endtask

    // Sideband responder: accept one request, answer three cycles later.
    task automatic do_req(input logic [3:0] req, input logic [3:0] resp, input string name);
        wait_sig(0, name);
        n_checks++;
        if (o_tx_sb_message !== req)
            $display("FAIL %s_code: got %b required %b", name, o_tx_sb_message, req);
        else n_pass++;
        i_falling_edge_busy = 1'b1;
        @(negedge CLK);
        i_falling_edge_busy = 1'b0;
        n_checks++;
        if (o_valid_out !== 1'b0)
            $display("FAIL %s_valid_drop: got %b required 0", name, o_valid_out);
        else n_pass++;
        @(negedge CLK);
        @(negedge CLK);
        i_msg_valid = 1'b1;
        i_rx_sb_message = resp;
        @(negedge CLK);
        i_msg_valid = 1'b0;
        i_rx_sb_message = '0;
    endtask

    task automatic pulse_pattern_done();
        i_laneid_pattern_done = 1'b1;
        @(negedge CLK);
        i_laneid_pattern_done = 1'b0;
    endtask

    task automatic expect_all_zero(input string name);
        n_checks++;
        if (all_o !== '0) $display("FAIL %s: got outputs %h required 0000", name, all_o);
        else n_pass++;
    endtask

    // Full training run; the expected path follows from pass counts, the
    // threshold and the retry allowance.
    task automatic run_training(input logic [15:0] r0, input logic [15:0] r1, input string tag);
        logic [15:0] res [2];
        int  attempts, exp_applies, pc, start_applies, held;
        bit  applied, finished;
        res[0] = r0; res[1] = r1;
        attempts = 0; exp_applies = 0; applied = 1'b0; finished = 1'b0;
        start_applies = apply_rises;
        i_enable = 1'b1;
        do_req(C_INIT_REQ, C_INIT_RESP, {tag, "_init"});
        for (int k = 0; k <= MAX_ATT && !finished; k++) begin
            do_req(C_CLEAR_REQ, C_CLEAR_RESP, {tag, "_clear"});
            wait_sig(1, {tag, "_laneid"});
            n_checks++;
            if (o_laneid_pattern_en !== 2'b11)
                $display("FAIL %s_laneid_en: got %b required 11", tag, o_laneid_pattern_en);
            else n_pass++;
            pulse_pattern_done();
            i_result_logged = res[k];
            do_req(C_RESULT_REQ, C_RESULT_RESP, {tag, "_result"});
            pc = $countones(res[k]);
            n_checks++;
            if (o_pass_count !== 5'(pc))
                $display("FAIL %s_pass_count: got %0d required %0d", tag, o_pass_count, pc);
            else n_pass++;
            if (pc >= THR) begin
                do_req(C_DONE_REQ, C_DONE_RESP, {tag, "_done"});
                wait_sig(3, {tag, "_module_end"});
                n_checks++;
                if (o_reversal_applied !== applied || o_train_error_req !== 1'b0)
                    $display("FAIL %s_done_flags: got applied=%b err=%b required applied=%b err=0",
                             tag, o_reversal_applied, o_train_error_req, applied);
                else n_pass++;
                finished = 1'b1;
            end else if (attempts < MAX_ATT) begin
                wait_sig(2, {tag, "_apply"});
                n_checks++;
                if (o_reversal_applied !== applied)
                    $display("FAIL %s_applied_before: got %b required %b", tag, o_reversal_applied, applied);
                else n_pass++;
                i_reversal_done = 1'b1;
                @(negedge CLK);
                i_reversal_done = 1'b0;
                attempts++; exp_applies++; applied = 1'b1;
                n_checks++;
                if (o_reversal_applied !== 1'b1)
                    $display("FAIL %s_applied_after: got %b required 1", tag, o_reversal_applied);
                else n_pass++;
            end else begin
                wait_sig(4, {tag, "_error"});
                held = 0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge CLK);
                    if (o_train_error_req === 1'b1) held++;
                end
                n_checks++;
                if (held != 5) $display("FAIL %s_error_held: got %0d/5 cycles required 5/5", tag, held);
                else n_pass++;
                finished = 1'b1;
            end
        end
        n_checks++;
        if (apply_rises - start_applies != exp_applies)
            $display("FAIL %s_apply_count: got %0d required %0d", tag, apply_rises - start_applies, exp_applies);
        else n_pass++;
        i_enable = 1'b0;
        @(negedge CLK);
        expect_all_zero({tag, "_disable"});
    endtask

    // Bring the DUT into WAIT_RESP for the result response.
    task automatic to_result_wait(input string tag);
        i_enable = 1'b1;
        do_req(C_INIT_REQ, C_INIT_RESP, {tag, "_init"});
        do_req(C_CLEAR_REQ, C_CLEAR_RESP, {tag, "_clear"});
        wait_sig(1, {tag, "_laneid"});
        pulse_pattern_done();
        wait_sig(0, {tag, "_resreq"});
        i_falling_edge_busy = 1'b1;
        @(negedge CLK);
        i_falling_edge_busy = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_enable = 1'b1;
        repeat (3) @(negedge CLK);
        expect_all_zero("reset_held_enabled");
        i_enable = 1'b0;
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        expect_all_zero("reset_release");
    endtask

    task automatic test_clean();
        run_training(16'hFFFF, 16'hFFFF, "clean");
    endtask

    task automatic test_single_reversal();
        run_training(16'h00FF, 16'hFFFF, "thr_exact");
        run_training(16'h007F, 16'hFFFF, "thr_minus1");
    endtask

    task automatic test_exhausted();
        run_training(16'h0001, 16'h0001, "exhausted");
    endtask

    // One response injected at offset k of WAIT_RESP (timeout limit TO).
    task automatic timeout_run(input int k_at, input logic [3:0] code, input bit exp_err, input string tag);
        int early;
        early = 0;
        i_enable = 1'b1;
        wait_sig(0, {tag, "_initreq"});
        i_falling_edge_busy = 1'b1;
        @(negedge CLK);
        i_falling_edge_busy = 1'b0;
        for (int k = 0; k < TO; k++) begin
            if (o_train_error_req !== 1'b0) early++;
            if (k == k_at) begin
                i_msg_valid = 1'b1;
                i_rx_sb_message = code;
            end
            @(negedge CLK);
            i_msg_valid = 1'b0;
            i_rx_sb_message = '0;
        end
        n_checks++;
        if (early != 0) $display("FAIL %s_early_error: got %0d early cycles required 0", tag, early);
        else n_pass++;
        n_checks++;
        if (exp_err && o_train_error_req !== 1'b1)
            $display("FAIL %s_error: got %b required 1", tag, o_train_error_req);
        else if (!exp_err && (o_valid_out !== 1'b1 || o_tx_sb_message !== C_CLEAR_REQ))
            $display("FAIL %s_clear_req: got valid=%b code=%b required valid=1 code=0011",
                     tag, o_valid_out, o_tx_sb_message);
        else n_pass++;
        i_enable = 1'b0;
        @(negedge CLK);
        expect_all_zero({tag, "_disable"});
    endtask

    task automatic test_timeout();
        timeout_run(5, C_DONE_RESP, 1'b1, "to_wrong_code");
        timeout_run(TO - 1, C_INIT_RESP, 1'b1, "to_last_cycle");
        timeout_run(TO - 2, C_INIT_RESP, 1'b0, "to_in_time");
    endtask

    task automatic test_busy();
        int leaked;
        i_busy_sideband = 1'b1;
        i_enable = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (o_valid_out !== 1'b0) $display("FAIL busy_idle_hold: got valid=%b required 0", o_valid_out);
        else n_pass++;
        i_busy_sideband = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (o_valid_out !== 1'b1 || o_tx_sb_message !== C_INIT_REQ)
            $display("FAIL busy_init_req: got valid=%b code=%b required valid=1 code=0001",
                     o_valid_out, o_tx_sb_message);
        else n_pass++;
        i_falling_edge_busy = 1'b1;
        @(negedge CLK);
        i_falling_edge_busy = 1'b0;
        @(negedge CLK);
        i_busy_sideband = 1'b1;
        i_msg_valid = 1'b1;
        i_rx_sb_message = C_INIT_RESP;
        @(negedge CLK);
        i_msg_valid = 1'b0;
        i_rx_sb_message = '0;
        leaked = 0;
        for (int c = 0; c < 3; c++) begin
            if (o_valid_out !== 1'b0) leaked++;
            @(negedge CLK);
        end
        n_checks++;
        if (leaked != 0) $display("FAIL busy_clear_hold: got %0d early request cycles required 0", leaked);
        else n_pass++;
        i_busy_sideband = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (o_valid_out !== 1'b1 || o_tx_sb_message !== C_CLEAR_REQ)
            $display("FAIL busy_clear_req: got valid=%b code=%b required valid=1 code=0011",
                     o_valid_out, o_tx_sb_message);
        else n_pass++;
        i_enable = 1'b0;
        @(negedge CLK);
        expect_all_zero("busy_disable");
    endtask

    task automatic test_abort();
        // Abort during lane-id pattern, then restart.
        i_enable = 1'b1;
        do_req(C_INIT_REQ, C_INIT_RESP, "ab_lid_init");
        do_req(C_CLEAR_REQ, C_CLEAR_RESP, "ab_lid_clear");
        wait_sig(1, "ab_lid_laneid");
        i_enable = 1'b0;
        @(negedge CLK);
        expect_all_zero("abort_laneid");
        i_enable = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (o_valid_out !== 1'b1 || o_tx_sb_message !== C_INIT_REQ)
            $display("FAIL abort_restart: got valid=%b code=%b required valid=1 code=0001",
                     o_valid_out, o_tx_sb_message);
        else n_pass++;
        i_enable = 1'b0;
        @(negedge CLK);
        // Abort during APPLY; a fresh run must again be allowed one reversal.
        i_enable = 1'b1;
        do_req(C_INIT_REQ, C_INIT_RESP, "ab_ap_init");
        do_req(C_CLEAR_REQ, C_CLEAR_RESP, "ab_ap_clear");
        wait_sig(1, "ab_ap_laneid");
        pulse_pattern_done();
        i_result_logged = 16'h0001;
        do_req(C_RESULT_REQ, C_RESULT_RESP, "ab_ap_result");
        wait_sig(2, "ab_ap_apply");
        i_enable = 1'b0;
        @(negedge CLK);
        expect_all_zero("abort_apply");
        run_training(16'h0003, 16'hFFFF, "after_abort");
        // Abort coinciding with a matching result response.
        to_result_wait("ab_match");
        i_result_logged = 16'hFFFF;
        i_msg_valid = 1'b1;
        i_rx_sb_message = C_RESULT_RESP;
        i_enable = 1'b0;
        @(negedge CLK);
        i_msg_valid = 1'b0;
        i_rx_sb_message = '0;
        expect_all_zero("abort_with_match");
    endtask

    task automatic test_sync_reset();
        to_result_wait("srst");
        i_result_logged = 16'hFFFF;
        i_msg_valid = 1'b1;
        i_rx_sb_message = C_RESULT_RESP;
        rst = 1'b1;
        @(negedge CLK);
        i_msg_valid = 1'b0;
        i_rx_sb_message = '0;
        expect_all_zero("sync_reset_mid_wait");
        rst = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (o_valid_out !== 1'b1 || o_tx_sb_message !== C_INIT_REQ)
            $display("FAIL sync_reset_restart: got valid=%b code=%b required valid=1 code=0001",
                     o_valid_out, o_tx_sb_message);
        else n_pass++;
        i_enable = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_random();
        logic [15:0] r0, r1;
        for (int it = 0; it < 8; it++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            if (it % 2 == 1) r0 = r0 & 16'($urandom) & 16'($urandom);
            if (it % 4 == 3) r1 = r1 & 16'($urandom);
            run_training(r0, r1, "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        i_enable = 1'b0;
        i_busy_sideband = 1'b0;
        i_falling_edge_busy = 1'b0;
        i_msg_valid = 1'b0;
        i_rx_sb_message = '0;
        i_laneid_pattern_done = 1'b0;
        i_reversal_done = 1'b0;
        i_result_logged = '0;
        test_reset();
        test_clean();
        test_single_reversal();
        test_exhausted();
        test_timeout();
        test_busy();
        test_abort();
        test_sync_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reversalmb_param_fsm.md
REVERSALMB_PARAM_FSM -- requirements
Module: reversalmb_param_fsm

Interface
REQ-001 SHALL have parameter NUM_LANES, default 16, number of lanes checked for reversal.
REQ-002 SHALL have parameter PASS_THRESHOLD, default 8, the minimum count of passing lanes (1..NUM_LANES) that means no reversal is needed.
REQ-003 SHALL have parameter MAX_ATTEMPTS, default 1, the number of reversals allowed before an error is raised.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the response-wait limit in cycles (>=2).
REQ-005 SHALL have ports CLK in 1, clock; rst in 1, reset, synchronous and active-high.
REQ-006 SHALL have ports i_enable in 1 (previous stage done; low aborts), i_busy_sideband in 1, i_falling_edge_busy in 1, i_msg_valid in 1, i_rx_sb_message in 4.
REQ-007 SHALL have ports i_laneid_pattern_done in 1, i_reversal_done in 1, i_result_logged in NUM_LANES (per-lane pass bits, sampled on a result_resp).
REQ-008 SHALL have ports o_tx_sb_message out 4, o_valid_out out 1, o_laneid_pattern_en out 2, o_apply_reversal_en out 1.
REQ-009 SHALL have ports o_module_end out 1, o_train_error_req out 1, o_reversal_applied out 1 and o_pass_count out $clog2(NUM_LANES+1).

Function
REQ-010 SHALL implement these states: IDLE, INIT_REQ, CLEAR_REQ, LANEID_PAT, RESULT_REQ, DONE_REQ, WAIT_RESP, CHECK, APPLY, DONE and ERROR.
REQ-011 SHALL move IDLE->INIT_REQ when i_enable=1 and i_busy_sideband=0.
REQ-012 SHALL enter each *_REQ state only when i_busy_sideband=0; CLEAR_REQ, RESULT_REQ and DONE_REQ entries wait in the prior state while busy is high.
REQ-013 SHALL move from a *_REQ state to WAIT_RESP when i_falling_edge_busy=1 and i_busy_sideband=0, and SHALL latch the expected response code.
REQ-014 SHALL advance from WAIT_RESP only when i_msg_valid=1 and i_rx_sb_message equals the expected response code; any other valid message is ignored.
REQ-015 SHALL route matched responses as follows: init_resp->CLEAR_REQ, clear_error_resp->LANEID_PAT, result_resp->CHECK, done_resp->DONE.
REQ-016 SHALL count cycles in WAIT_RESP, clearing the count on entry, and SHALL go to ERROR if no match arrives within TIMEOUT_CYCLES cycles.
REQ-017 SHALL register the popcount of i_result_logged into o_pass_count in the cycle a result_resp is matched; the popcount has full width and does not saturate.
REQ-018 SHALL resolve CHECK in one cycle: o_pass_count>=PASS_THRESHOLD->DONE_REQ; else attempts<MAX_ATTEMPTS->APPLY with attempts+1; else ERROR.
REQ-019 SHALL hold APPLY until i_reversal_done=1, then go to CLEAR_REQ (through the busy check) and set o_reversal_applied=1.
REQ-020 SHALL move LANEID_PAT->RESULT_REQ on i_laneid_pattern_done.
REQ-021 SHALL register outputs from the next-state decode, so each output is valid in the first cycle of its state.
REQ-022 SHALL drive o_valid_out=1 with the matching request code (init 0001, clear 0011, result 0101, done 0111) in every *_REQ cycle, and 0/0000 otherwise.
REQ-023 SHALL drive o_laneid_pattern_en=2'b11 in LANEID_PAT, o_apply_reversal_en=1 in APPLY, o_module_end=1 in DONE and o_train_error_req=1 in ERROR (as a level); each output is 0 elsewhere.
REQ-024 SHALL hold DONE and ERROR until i_enable=0.
REQ-025 SHALL, when i_enable=0 in any non-IDLE state, go to IDLE on the next edge and clear the attempts counter, o_reversal_applied and o_pass_count; an abort takes priority over every other transition.
REQ-026 SHALL give an abort priority over a response matched in the same cycle, and a timeout priority over a response that matches on the final timeout cycle.

Reset
REQ-027 SHALL, while rst=1 at a CLK edge, enter IDLE and zero every output, the attempts counter, the timeout counter and the expected-code register.

Structure
REQ-028 SHALL place the sideband message codes (0001..1000) and the state encoding in the shared MBINIT package.
REQ-029 SHALL instantiate one sub-module, lane_popcount (parameter NUM_LANES), which is purely combinational.

Verification
REQ-030 SHALL pass a clean run: responses are returned 3 cycles after each request and result=16'hFFFF -> o_pass_count=16, no APPLY, o_module_end=1, o_reversal_applied=0.
REQ-031 SHALL pass a single reversal: the first result is 16'h00FF (8 passing) -> DONE_REQ and no reversal; when the first result is 16'h007F (7 passing) instead -> APPLY, then clear_req (0011) is resent, the second result 16'hFFFF -> DONE and o_reversal_applied=1.
REQ-032 SHALL pass exhausted attempts: two results of 16'h0001 with MAX_ATTEMPTS=1 -> one APPLY, then ERROR with o_train_error_req held high until i_enable=0.
REQ-033 SHALL pass timeout: with TIMEOUT_CYCLES=16 and no init_resp -> ERROR 16 cycles after entering WAIT_RESP; a wrong code (done_resp) sent meanwhile is ignored.
REQ-034 SHALL pass abort: i_enable dropped during LANEID_PAT and during APPLY -> IDLE on the next cycle and all outputs 0; re-enabling restarts at INIT_REQ with attempts=0.
REQ-035 SHALL pass sync reset: rst=1 asserted mid-WAIT_RESP together with a matching response -> IDLE and all outputs 0 after the edge.
